// File: rtl/cache_line_fetch.sv
// Cache miss line fetcher: issues one memory read per miss tag, assembles the
// beat responses into a full line and returns {tag, line} in request order.
module cache_line_fetch #(
  parameter int unsigned TAGS_WIDTH      = 48,
  parameter int unsigned CACHE_SIZE      = 512,
  parameter int unsigned DATA_PORT_SIZE  = 128,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [TAGS_WIDTH-1:0]            miss_addr_stream_tdata,
  input  logic                             miss_addr_stream_tvalid,
  output logic                             miss_addr_stream_tready,
  output logic [TAGS_WIDTH+CACHE_SIZE-1:0] line_data_stream_tdata,
  output logic                             line_data_stream_tvalid,
  input  logic                             line_data_stream_tready,
  output logic [TAGS_WIDTH-1:0]            mem_req_stream_tdata,
  output logic                             mem_req_stream_tvalid,
  input  logic                             mem_req_stream_tready,
  input  logic [DATA_PORT_SIZE-1:0]        mem_rsp_stream_tdata,
  input  logic                             mem_rsp_stream_tvalid,
  input  logic                             mem_rsp_stream_tlast,
  output logic                             mem_rsp_stream_tready,
  output logic                             proto_err
);

  localparam int unsigned BEATS  = CACHE_SIZE / DATA_PORT_SIZE;
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned PTR_W  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CNT_W  = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {COLLECT = 2'd0, HOLD = 2'd1, DRAIN = 2'd2} state_t;

  state_t                  r_state, w_state_nxt;
  logic                    r_req_valid;
  logic [TAGS_WIDTH-1:0]   r_req_tag;
  logic [CNT_W-1:0]        r_outstanding;
  logic [CNT_W-1:0]        r_fifo_cnt;
  logic [PTR_W-1:0]        r_wr_ptr, r_rd_ptr;
  logic [TAGS_WIDTH-1:0]   r_fifo_mem [MAX_OUTSTANDING];
  logic [BEAT_W-1:0]       r_beat;
  logic [CACHE_SIZE-1:0]   r_line;
  logic                    r_proto_err;
  logic                    r_drain_done;

  logic w_fifo_full, w_fifo_empty, w_miss_ready, w_miss_fire, w_req_fire;
  logic w_rsp_ready, w_rsp_fire, w_line_valid, w_line_fire, w_drain_pop, w_pop;
  logic w_collect_beat, w_last_beat, w_mismatch;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_fifo_full    = (r_fifo_cnt == CNT_W'(MAX_OUTSTANDING));
  assign w_fifo_empty   = (r_fifo_cnt == '0);
  assign w_miss_ready   = !rst && (r_outstanding < CNT_W'(MAX_OUTSTANDING)) && !w_fifo_full &&
                          (!r_req_valid || mem_req_stream_tready);
  assign w_miss_fire    = w_miss_ready && miss_addr_stream_tvalid;
  assign w_req_fire     = !rst && r_req_valid && mem_req_stream_tready;
  assign w_rsp_fire     = w_rsp_ready && mem_rsp_stream_tvalid;
  assign w_line_fire    = w_line_valid && line_data_stream_tready;
  assign w_pop          = w_line_fire || w_drain_pop;
  assign w_collect_beat = w_rsp_fire && (r_state == COLLECT);
  assign w_last_beat    = (r_beat == BEAT_W'(BEATS - 1));
  assign w_mismatch     = w_collect_beat && (mem_rsp_stream_tlast != w_last_beat);

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= COLLECT;
    else     r_state <= w_state_nxt;
  end

  // FSM next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      COLLECT: if (w_mismatch)                       w_state_nxt = DRAIN;
               else if (w_collect_beat && w_last_beat) w_state_nxt = HOLD;
      HOLD:    if (w_line_fire)                      w_state_nxt = COLLECT;
      DRAIN:   if (w_drain_pop)                      w_state_nxt = COLLECT;
      default:                                       w_state_nxt = COLLECT;
    endcase
  end

  // FSM outputs; an early tlast ends the line, so DRAIN then only retires the tag
  always_comb begin
    w_rsp_ready  = 1'b0;
    w_line_valid = 1'b0;
    w_drain_pop  = 1'b0;
    if (!rst) begin
      case (r_state)
        COLLECT: w_rsp_ready = !w_fifo_empty;
        HOLD:    w_line_valid = 1'b1;
        DRAIN: begin
          w_rsp_ready = !r_drain_done && !w_fifo_empty;
          w_drain_pop = r_drain_done || (w_rsp_fire && mem_rsp_stream_tlast);
        end
        default: ;
      endcase
    end
  end

  // Control state: request register, counters, tag FIFO pointers, error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_req_valid   <= 1'b0;
      r_outstanding <= '0;
      r_fifo_cnt    <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_beat        <= '0;
      r_proto_err   <= 1'b0;
      r_drain_done  <= 1'b0;
    end else begin
      if (w_miss_fire)     r_req_valid <= 1'b1;
      else if (w_req_fire) r_req_valid <= 1'b0;

      case ({w_miss_fire, w_pop})
        2'b10: begin
          r_outstanding <= r_outstanding + CNT_W'(1);
          r_fifo_cnt    <= r_fifo_cnt + CNT_W'(1);
        end
        2'b01: begin
          r_outstanding <= r_outstanding - CNT_W'(1);
          r_fifo_cnt    <= r_fifo_cnt - CNT_W'(1);
        end
        default: ;
      endcase
      if (w_miss_fire) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)       r_rd_ptr <= ptr_inc(r_rd_ptr);

      if (w_collect_beat) r_beat <= (w_mismatch || w_last_beat) ? '0 : r_beat + BEAT_W'(1);

      if (w_mismatch) begin
        r_proto_err  <= 1'b1;
        r_drain_done <= mem_rsp_stream_tlast;
      end else if (w_drain_pop) begin
        r_drain_done <= 1'b0;
      end
    end
  end

  // Data storage, no reset needed
  always_ff @(posedge clk) begin
    if (w_miss_fire) begin
      r_fifo_mem[r_wr_ptr] <= miss_addr_stream_tdata;
      r_req_tag            <= miss_addr_stream_tdata;
    end
    if (w_collect_beat) begin
      for (int k = 0; k < BEATS; k++) begin
        if (r_beat == BEAT_W'(k)) r_line[k*DATA_PORT_SIZE +: DATA_PORT_SIZE] <= mem_rsp_stream_tdata;
      end
    end
  end

  assign miss_addr_stream_tready = w_miss_ready;
  assign mem_req_stream_tvalid   = !rst && r_req_valid;
  assign mem_req_stream_tdata    = r_req_tag;
  assign line_data_stream_tvalid = w_line_valid;
  assign line_data_stream_tdata  = {r_fifo_mem[r_rd_ptr], r_line};
  assign mem_rsp_stream_tready   = w_rsp_ready;
  assign proto_err               = !rst && r_proto_err;

endmodule
